// File: rtl/card_dealer_deck.sv
// Deals cards from a 52-card deck using an external random source, rejecting repeats and
// falling back to a linear probe. Define CARD_DEALER_REJECT_CNT_EN to add reject_cnt_o.
module card_dealer_deck #(
   parameter int unsigned RND_W     = 6,
   parameter int unsigned MAX_RETRY = 4
) (
   input  logic             clk_cd_i,
   input  logic             rst_cd_i,
   input  logic             req_card_i,
   input  logic             shuffle_i,
   output logic             req_rnd_o,
   input  logic             rnd_valid_i,
   input  logic [RND_W-1:0] rnd_data_i,
   output logic             card_valid_o,
   output logic [3:0]       card_rank_o,
   output logic [1:0]       card_suit_o,
   output logic [3:0]       card_points_o,
   output logic [5:0]       cards_left_o,
   output logic             deck_empty_o,
`ifdef CARD_DEALER_REJECT_CNT_EN
   output logic [7:0]       reject_cnt_o,
`endif
   output logic             busy_o
);

   typedef enum logic [2:0] {StIdle, StReq, StWait, StCheck, StProbe, StDeal} state_e;

   localparam logic [3:0] RetryLast = 4'(MAX_RETRY - 1);

   state_e      state_q, state_d;
   logic [51:0] mask_q, mask_d;
   logic [5:0]  left_q, left_d;
   logic        empty_q, empty_d;
   logic [3:0]  retry_q, retry_d;
   logic [5:0]  idx_q, idx_d;
   logic [5:0]  probe_q, probe_d;
   logic [5:0]  deal_q, deal_d;
   logic [3:0]  rank_q, rank_d;
   logic [1:0]  suit_q, suit_d;
   logic [3:0]  points_q, points_d;
   logic        load_card;
   logic [5:0]  load_idx;
   logic        reject;
   logic [63:0] mask_ext;

   generate
      if (RND_W > 6) begin : g_rnd_hi
         logic unused_rnd_hi;
         assign unused_rnd_hi = ^rnd_data_i[RND_W-1:6];
      end
   endgenerate

   // Indices 52..63 look permanently dealt, so one lookup covers both rejection causes.
   assign mask_ext = {12'hfff, mask_q};

   function automatic logic [9:0] decode_card(logic [5:0] idx);
      logic [1:0] suit;
      logic [3:0] rem;
      logic [3:0] rank;
      logic [3:0] pts;
      if (idx < 6'd13) begin
         suit = 2'd0;
         rem  = idx[3:0];
      end else if (idx < 6'd26) begin
         suit = 2'd1;
         rem  = 4'(idx - 6'd13);
      end else if (idx < 6'd39) begin
         suit = 2'd2;
         rem  = 4'(idx - 6'd26);
      end else begin
         suit = 2'd3;
         rem  = 4'(idx - 6'd39);
      end
      rank = rem + 4'd1;
      pts  = (rank > 4'd10) ? 4'd10 : rank;
      return {rank, suit, pts};
   endfunction

   always_comb begin
      state_d   = state_q;
      mask_d    = mask_q;
      left_d    = left_q;
      empty_d   = empty_q;
      retry_d   = retry_q;
      idx_d     = idx_q;
      probe_d   = probe_q;
      deal_d    = deal_q;
      load_card = 1'b0;
      load_idx  = idx_q;
      reject    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (shuffle_i) begin
               mask_d  = '0;
               left_d  = 6'd52;
               empty_d = 1'b0;
            end else if (req_card_i && (left_q != 6'd0)) begin
               state_d = StReq;
               retry_d = '0;
            end
         end
         StReq: state_d = StWait;
         StWait: begin
            if (rnd_valid_i) begin
               idx_d   = rnd_data_i[5:0];
               state_d = StCheck;
            end
         end
         StCheck: begin
            if (!mask_ext[idx_q]) begin
               deal_d    = idx_q;
               load_card = 1'b1;
               state_d   = StDeal;
            end else begin
               reject = 1'b1;
               if (retry_q == RetryLast) begin
                  probe_d = (idx_q >= 6'd52) ? idx_q - 6'd52 : idx_q;
                  state_d = StProbe;
               end else begin
                  retry_d = retry_q + 4'd1;
                  state_d = StReq;
               end
            end
         end
         StProbe: begin
            if (!mask_q[probe_q]) begin
               deal_d    = probe_q;
               load_idx  = probe_q;
               load_card = 1'b1;
               state_d   = StDeal;
            end else begin
               probe_d = (probe_q == 6'd51) ? 6'd0 : probe_q + 6'd1;
            end
         end
         StDeal: begin
            mask_d[deal_q] = 1'b1;
            left_d         = left_q - 6'd1;
            empty_d        = (left_q == 6'd1);
            state_d        = StIdle;
         end
         default: state_d = StIdle;
      endcase
      {rank_d, suit_d, points_d} = load_card ? decode_card(load_idx)
                                             : {rank_q, suit_q, points_q};
   end

   always_ff @(posedge clk_cd_i) begin
      if (rst_cd_i) begin
         state_q  <= StIdle;
         mask_q   <= '0;
         left_q   <= 6'd52;
         empty_q  <= 1'b0;
         retry_q  <= '0;
         idx_q    <= '0;
         probe_q  <= '0;
         deal_q   <= '0;
         rank_q   <= '0;
         suit_q   <= '0;
         points_q <= '0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         left_q   <= left_d;
         empty_q  <= empty_d;
         retry_q  <= retry_d;
         idx_q    <= idx_d;
         probe_q  <= probe_d;
         deal_q   <= deal_d;
         rank_q   <= rank_d;
         suit_q   <= suit_d;
         points_q <= points_d;
      end
   end

`ifdef CARD_DEALER_REJECT_CNT_EN
   logic [7:0] rej_cnt_q;

   always_ff @(posedge clk_cd_i) begin
      if (rst_cd_i || ((state_q == StIdle) && shuffle_i)) begin
         rej_cnt_q <= '0;
      end else if (reject && (rej_cnt_q != 8'hff)) begin
         rej_cnt_q <= rej_cnt_q + 8'd1;
      end
   end

   assign reject_cnt_o = rej_cnt_q;
`else
   logic unused_reject;
   assign unused_reject = reject;
`endif

   assign req_rnd_o     = (state_q == StReq);
   assign card_valid_o  = (state_q == StDeal);
   assign busy_o        = (state_q != StIdle);
   assign card_rank_o   = rank_q;
   assign card_suit_o   = suit_q;
   assign card_points_o = points_q;
   assign cards_left_o  = left_q;
   assign deck_empty_o  = empty_q;

endmodule

// File: tb/tb_card_dealer_deck.sv
// Scoreboard bench for card_dealer_deck: the bench plays the random source and predicts each
// dealt card from a deck model.
module tb_card_dealer_deck;

   localparam int MAX_RETRY = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_card = 1'b0;
   logic       shuffle = 1'b0;
   logic       rnd_valid = 1'b0;
   logic [5:0] rnd_data = '0;
   logic       req_rnd, card_valid, deck_empty, busy;
   logic [3:0] card_rank, card_points;
   logic [1:0] card_suit;
   logic [5:0] cards_left;
`ifdef CARD_DEALER_REJECT_CNT_EN
   logic [7:0] reject_cnt;
`endif

   card_dealer_deck #(.RND_W(6), .MAX_RETRY(MAX_RETRY)) dut (
      .clk_cd_i      (clk),
      .rst_cd_i      (rst),
      .req_card_i    (req_card),
      .shuffle_i     (shuffle),
      .req_rnd_o     (req_rnd),
      .rnd_valid_i   (rnd_valid),
      .rnd_data_i    (rnd_data),
      .card_valid_o  (card_valid),
      .card_rank_o   (card_rank),
      .card_suit_o   (card_suit),
      .card_points_o (card_points),
      .cards_left_o  (cards_left),
      .deck_empty_o  (deck_empty),
`ifdef CARD_DEALER_REJECT_CNT_EN
      .reject_cnt_o  (reject_cnt),
`endif
      .busy_o        (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   typedef struct {
      int rank;
      int suit;
      int pts;
      int draws;
      bit direct;
   } exp_t;

   exp_t exp_q[$];
   bit   dealt[52];
   int   left_m = 52;

   function automatic void model_reset();
      for (int i = 0; i < 52; i++) dealt[i] = 1'b0;
      left_m = 52;
   endfunction

   // Draws are tried in order; after MAX_RETRY rejections walk forward from the last draw.
   function automatic exp_t model_deal(input int vals[MAX_RETRY]);
      exp_t e;
      int idx = -1;
      int v = 0;
      for (int k = 0; k < MAX_RETRY; k++) begin
         v = vals[k];
         e.draws = k + 1;
         if (v < 52 && !dealt[v]) begin
            idx = v;
            break;
         end
      end
      e.direct = (idx >= 0);
      if (idx < 0) begin
         idx = v % 52;
         while (dealt[idx]) idx = (idx + 1) % 52;
      end
      dealt[idx] = 1'b1;
      left_m--;
      e.rank = idx % 13 + 1;
      e.suit = idx / 13;
      e.pts  = (e.rank > 10) ? 10 : e.rank;
      return e;
   endfunction

   // Random source: answers each req_rnd pulse after a random delay.
   int src_q[$];
   bit src_hold = 1'b0;
   int src_dly_max = 0;
   int req_cnt = 0;
   int first_req_cyc = -1;
   int valid_cyc = 0;

   initial begin
      int dly;
      int v;
      forever begin
         @(posedge clk);
         #1;
         if (req_rnd === 1'b1) begin
            req_cnt++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
            if (!src_hold) begin
               dly = $urandom_range(0, src_dly_max);
               @(posedge clk);
               #1;
               repeat (dly) begin
                  @(posedge clk);
                  #1;
               end
               v = (src_q.size() > 0) ? src_q.pop_front() : int'($urandom_range(0, 63));
               rnd_data  = 6'(v);
               rnd_valid = 1'b1;
               valid_cyc = cyc;
               @(posedge clk);
               #1;
               rnd_valid = 1'b0;
               rnd_data  = 6'($urandom);
            end
         end
      end
   end

   // Monitor: every card_valid pulse must match the head of the scoreboard.
   int cards_seen = 0;

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (card_valid === 1'b1) begin
            cards_seen++;
            if (exp_q.size() == 0) begin
               check("spurious card_valid", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("card rank", int'(card_rank), e.rank);
               check("card suit", int'(card_suit), e.suit);
               check("card points", int'(card_points), e.pts);
               if (e.direct) check("valid-to-card latency", cyc - valid_cyc, 2);
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      exp_q.delete();
      src_q.delete();
   endtask

   task automatic deal(input int vals[MAX_RETRY]);
      exp_t e;
      int seen0;
      int rc;
      int i;
      e = model_deal(vals);
      for (int k = 0; k < MAX_RETRY; k++) src_q.push_back(vals[k]);
      exp_q.push_back(e);
      req_cnt = 0;
      first_req_cyc = -1;
      seen0 = cards_seen;
      @(posedge clk);
      #1;
      req_card = 1'b1;
      rc = cyc;
      @(posedge clk);
      #1;
      req_card = 1'b0;
      i = 0;
      while (cards_seen == seen0 && i < 500) begin
         @(posedge clk);
         i++;
      end
      #1;
      if (cards_seen == seen0) begin
         check("deal timeout", 0, 1);
         exp_q.delete();
      end
      src_q.delete();
      check("busy after deal", int'(busy), 0);
      check("cards_left", int'(cards_left), left_m);
      check("deck_empty", int'(deck_empty), int'(left_m == 0));
      check("req_rnd pulses", req_cnt, e.draws);
      check("req-to-req_rnd latency", first_req_cyc - rc, 1);
   endtask

   task automatic do_shuffle(input bit with_req);
      req_cnt = 0;
      @(posedge clk);
      #1;
      shuffle  = 1'b1;
      req_card = with_req;
      @(posedge clk);
      #1;
      shuffle  = 1'b0;
      req_card = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("left after shuffle", int'(cards_left), 52);
      check("empty after shuffle", int'(deck_empty), 0);
      check("no req_rnd on shuffle", req_cnt, 0);
   endtask

   initial begin
      int vals[MAX_RETRY];
      int i;
      model_reset();
      do_reset();
      @(negedge clk);
      check("reset cards_left", int'(cards_left), 52);
      check("reset deck_empty", int'(deck_empty), 0);
      check("reset busy", int'(busy), 0);
      check("reset req_rnd", int'(req_rnd), 0);
      check("reset card_valid", int'(card_valid), 0);
      check("reset rank", int'(card_rank), 0);
      check("reset suit", int'(card_suit), 0);
      check("reset points", int'(card_points), 0);

      deal('{0, 0, 0, 0});
      do_reset();
      deal('{24, 24, 24, 24});
      deal('{24, 51, 5, 5});
      deal('{63, 63, 63, 63});

      do_reset();
      for (int v = 0; v < 52; v++) deal('{v, v, v, v});
      check("full deal empty", int'(deck_empty), 1);
      req_cnt = 0;
      @(posedge clk);
      #1;
      req_card = 1'b1;
      @(posedge clk);
      #1;
      req_card = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("empty deck req_rnd", req_cnt, 0);
      check("empty deck busy", int'(busy), 0);
      do_shuffle(1'b1);

      src_dly_max = 3;
      repeat (150) begin
         if (left_m == 0 || $urandom_range(0, 19) == 0) begin
            do_shuffle(1'b0);
         end else begin
            for (int k = 0; k < MAX_RETRY; k++) vals[k] = $urandom_range(0, 63);
            deal(vals);
         end
      end

      // Reset while waiting for the random source; a late rnd_valid must be ignored.
      src_hold = 1'b1;
      @(posedge clk);
      #1;
      req_card = 1'b1;
      @(posedge clk);
      #1;
      req_card = 1'b0;
      i = 0;
      while (req_rnd !== 1'b1 && i < 20) begin
         @(posedge clk);
         #2;
         i++;
      end
      @(posedge clk);
      #2;
      check("in WAIT busy", int'(busy), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      rnd_valid = 1'b1;
      rnd_data  = 6'd7;
      @(posedge clk);
      #1;
      rnd_valid = 1'b0;
      model_reset();
      repeat (5) @(posedge clk);
      #1;
      check("abort busy", int'(busy), 0);
      check("abort cards_left", int'(cards_left), 52);
      check("abort rank cleared", int'(card_rank), 0);
      src_hold = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
      $fatal(1);
   end

endmodule

// File: doc/card_dealer_deck.md
Name: card_dealer_deck

Overview:
- Downstream consumer of the seed_random_4 random source in the blackjack datapath.
- On a deal request from the game FSM, it requests a random value from seed_random_4, maps it to one card of a 52-card deck and rejects cards already dealt.
- Tracks the dealt set and the remaining count, and presents rank, suit and blackjack points to the hand-scoring logic.
- Guaranteed termination: after MAX_RETRY rejections it linear-probes to the next undealt card.

Parameters:
- RND_W, 6, width of the random input; must be >= 6; only the low 6 bits are used.
- MAX_RETRY, 4, random draws attempted before falling back to linear probe; range 1..15.

Ports:
- clk_cd_i  input  1  system clock, all logic on rising edge.
- rst_cd_i  input  1  synchronous, active-high reset.
- req_card_i  input  1  deal request from game FSM; sampled only in IDLE.
- shuffle_i  input  1  return all 52 cards to the deck; sampled only in IDLE.
- req_rnd_o  output  1  one-cycle request to seed_random_4 (drives its req_card_state_cp).
- rnd_valid_i  input  1  random value valid; sampled only in WAIT.
- rnd_data_i  input  RND_W  random value from seed_random_4.
- card_valid_o  output  1  one-cycle pulse: new card on card_* outputs.
- card_rank_o  output  4  1..13 (1=A, 11=J, 12=Q, 13=K).
- card_suit_o  output  2  0..3.
- card_points_o  output  4  blackjack points: A=1, 2..10 as rank, J/Q/K=10.
- cards_left_o  output  6  undealt cards, 0..52.
- deck_empty_o  output  1  high when cards_left_o==0.
- busy_o  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_cd_i=1 at clock edge):
  - State = IDLE; dealt mask (52 bits) cleared; cards_left_o = 52; retry count = 0.
  - req_rnd_o, card_valid_o, busy_o, deck_empty_o = 0; card_rank_o, card_suit_o, card_points_o = 0.
  - Reset mid-operation aborts immediately; any in-flight rnd_valid_i is ignored.
- Card index idx = rnd_data_i[5:0]:
  - suit = idx / 13; rank = (idx mod 13) + 1.
  - idx 52..63 is invalid and is rejected.
- States: IDLE, REQ, WAIT, CHECK, PROBE, DEAL.
- IDLE:
  - shuffle_i=1: clear mask, cards_left = 52, stay in IDLE. shuffle_i has priority over a simultaneous req_card_i, which is dropped.
  - Else req_card_i=1 and cards_left != 0: go to REQ, retry = 0.
  - req_card_i while deck empty: ignored; no req_rnd_o, no card_valid_o.
- REQ: req_rnd_o = 1 for exactly this cycle; go to WAIT.
- WAIT: hold until rnd_valid_i = 1; latch rnd_data_i[5:0]; go to CHECK. No timeout. rnd_valid_i outside WAIT is ignored.
- CHECK:
  - idx < 52 and mask[idx] = 0: go to DEAL with the deal index = idx.
  - Otherwise, if retry == MAX_RETRY-1: go to PROBE with p = (idx >= 52 ? idx-52 : idx).
  - Otherwise retry++ and go to REQ.
- PROBE:
  - Each cycle: if mask[p] = 0, go to DEAL with the deal index = p; else p = (p == 51 ? 0 : p+1).
  - Finds a card within 52 cycles because cards_left > 0 is guaranteed.
- DEAL (one cycle):
  - card_valid_o = 1; card_* registered from the deal index; mask[index] set; cards_left decremented; next state IDLE.
  - card_* outputs hold their values until the next DEAL or reset.
  - deck_empty_o is registered and becomes 1 in the cycle after the 52nd deal.
- Latency: req_card_i in IDLE at cycle n gives req_rnd_o at n+1. With rnd_valid_i at cycle m (first draw accepted), CHECK is at m+1 and card_valid_o at m+2.
- shuffle_i and req_card_i received while busy are ignored, not queued.

Optional Feature:
- Macro: CARD_DEALER_REJECT_CNT_EN.
- Defined:
  - Adds output reject_cnt_o [7:0], a saturating count (max 255) of every CHECK rejection (invalid or already-dealt index) since reset or the last accepted shuffle.
  - Cleared by reset and by shuffle.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then req_card_i with rnd_data_i = 0 valid on the first WAIT cycle -> req_rnd_o 1 cycle; card_valid_o 2 cycles after rnd_valid_i with rank=1, suit=0, points=1, cards_left_o=51.
- Deal idx 24, then request again returning 24, then 51 -> first return rejected (second req_rnd_o issued); card: rank=13, suit=3, points=10, cards_left_o=50.
- MAX_RETRY=4, source always returns 63 -> exactly 4 req_rnd_o pulses; probe from 11 yields idx 11 (rank=12, suit=0, points=10).
- Deal all 52 cards with sequential values 0..51 -> deck_empty_o=1, cards_left_o=0; a further req_card_i gives no req_rnd_o and no card_valid_o.
- shuffle_i and req_card_i high together in IDLE with deck empty -> cards_left_o=52, deck_empty_o=0, no req_rnd_o.
- Reset asserted while in WAIT, rnd_valid_i pulsed the next cycle -> no card_valid_o, cards_left_o=52, busy_o=0.
